// File: rtl/mips_mem_responder.sv
// rtl/mips_mem_responder.sv - word RAM responder with fixed-latency req/ready handshake for the multicycle MIPS core
// Define MIPS_MEM_MMIO_EN to map the I/O page at 0xFFFFFFxx (io_out register and cycle counter).
module mips_mem_responder #(
    parameter int ADDR_BITS = 6,
    parameter int LATENCY   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic [31:0] adr,
    input  logic [31:0] writedata,
    input  logic        memwrite,
    output logic [31:0] readdata,
    output logic        ready,
    output logic        busy,
    output logic [31:0] io_out
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t              state;
    logic [3:0]          cnt;
    logic [31:0]         lat_adr;
    logic [31:0]         lat_wdata;
    logic                lat_we;
    logic [31:0]         mem [0:(1<<ADDR_BITS)-1];

    logic [31:0]         cur_adr;
    logic [31:0]         cur_wdata;
    logic                cur_we;
    logic                enter_resp;
    logic                is_io;
    logic                ram_we;
    logic [ADDR_BITS-1:0] idx;
    logic [31:0]         io_rdata;

    // With LATENCY=1 the transaction reaches RESP straight from IDLE, so it uses the live inputs.
    always_comb begin
        cur_adr   = lat_adr;
        cur_wdata = lat_wdata;
        cur_we    = lat_we;
        if (state == IDLE) begin
            cur_adr   = adr;
            cur_wdata = writedata;
            cur_we    = memwrite;
        end
    end

    assign enter_resp = !reset &&
                        (((state == IDLE) && req && (LATENCY == 1)) ||
                         ((state == WAIT) && (cnt == 4'd1)));
    assign idx    = cur_adr[ADDR_BITS+1:2];
    assign ram_we = enter_resp && cur_we && !is_io;

`ifdef MIPS_MEM_MMIO_EN
    logic [31:0] cycles;
    wire         unused_adr_bits = ^cur_adr[1:0];

    assign is_io = (cur_adr[31:8] == 24'hFFFFFF);

    always_comb begin
        io_rdata = '0;
        case (cur_adr[7:2])
            6'h00:   io_rdata = io_out;
            6'h01:   io_rdata = cycles;
            default: io_rdata = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) cycles <= '0;
        else       cycles <= cycles + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (reset)
            io_out <= '0;
        else if (enter_resp && is_io && cur_we && (cur_adr[7:2] == 6'h00))
            io_out <= cur_wdata;
    end
`else
    // Without the I/O page every address bit above the word index simply aliases.
    wire unused_adr_bits = ^{cur_adr[31:ADDR_BITS+2], cur_adr[1:0]};

    assign is_io    = 1'b0;
    assign io_rdata = '0;
    assign io_out   = '0;
`endif

    always_ff @(posedge clk) begin
        if (ram_we)
            mem[idx] <= cur_wdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            ready    <= 1'b0;
            busy     <= 1'b0;
            readdata <= '0;
        end else begin
            ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        lat_adr   <= adr;
                        lat_wdata <= writedata;
                        lat_we    <= memwrite;
                        cnt       <= 4'(LATENCY - 1);
                        busy      <= 1'b1;
                        if (LATENCY == 1) begin
                            state <= RESP;
                            ready <= 1'b1;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state <= RESP;
                        ready <= 1'b1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
            // Writes echo their own data so the core sees a defined readdata either way.
            if (enter_resp)
                readdata <= cur_we ? cur_wdata : (is_io ? io_rdata : mem[idx]);
        end
    end
endmodule

// File: tb/tb_mips_mem_responder.sv
// tb/tb_mips_mem_responder.sv - directed self-checking bench for mips_mem_responder (LATENCY 2 and 1 instances)
module tb_mips_mem_responder;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req = 1'b0, memwrite = 1'b0;
    logic [31:0] adr = '0, writedata = '0;
    logic [31:0] readdata, io_out;
    logic        ready, busy;

    logic        req_b = 1'b0, we_b = 1'b0;
    logic [31:0] adr_b = '0, wd_b = '0;
    logic [31:0] rd_b, io_b;
    logic        ready_b, busy_b;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mips_mem_responder #(.ADDR_BITS(6), .LATENCY(2)) dut (
        .clk(clk), .reset(reset), .req(req), .adr(adr), .writedata(writedata),
        .memwrite(memwrite), .readdata(readdata), .ready(ready), .busy(busy), .io_out(io_out)
    );

    mips_mem_responder #(.ADDR_BITS(6), .LATENCY(1)) dut_l1 (
        .clk(clk), .reset(reset), .req(req_b), .adr(adr_b), .writedata(wd_b),
        .memwrite(we_b), .readdata(rd_b), .ready(ready_b), .busy(busy_b), .io_out(io_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One transaction on the LATENCY=2 instance; inputs are scrambled right after acceptance.
    task automatic xact(input logic [31:0] a, input logic [31:0] d, input logic w,
                        output logic [31:0] rd, output int lat, output int t_rdy,
                        output logic b1, output logic r_after, output logic b_after);
        int n;
        n = 0;
        while (busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        adr = a; writedata = d; memwrite = w; req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0; adr = 32'h10; writedata = 32'hBAD0BAD0; memwrite = ~w;
        lat = 99; rd = 'x; b1 = 1'b0; t_rdy = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 1) b1 = busy;
            if (ready) begin
                lat = i; rd = readdata; t_rdy = cyc;
                break;
            end
        end
        @(negedge clk);
        r_after = ready; b_after = busy;
        memwrite = 1'b0;
    endtask

    task automatic rw(input string tag, input logic [31:0] a, input logic [31:0] d,
                      input logic w, input logic [31:0] exp);
        logic [31:0] rd;
        int lat, t;
        logic b1, ra, ba;
        xact(a, d, w, rd, lat, t, b1, ra, ba);
        check({tag, "_lat"}, lat, 32'd2);
        check({tag, "_data"}, rd, exp);
    endtask

    initial begin
        logic [31:0] rd, rd0, rd1;
        int lat, t0, t1;
        logic b1, ra, ba;

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_ready", {31'd0, ready}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_readdata", readdata, 32'd0);
        check("rst_io_out", io_out, 32'd0);
        check("rst_l1_busy", {31'd0, busy_b}, 32'd0);
`ifndef MIPS_MEM_MMIO_EN
        check("io_tied_l1", io_b, 32'd0);
`endif

        // First write: busy the cycle after accept, ready exactly at accept+2, then quiet.
        xact(32'h10, 32'hDEADBEEF, 1'b1, rd, lat, t0, b1, ra, ba);
        check("wr_lat", lat, 32'd2);
        check("wr_echo", rd, 32'hDEADBEEF);
        check("wr_busy_wait", {31'd0, b1}, 32'd1);
        check("wr_ready_after", {31'd0, ra}, 32'd0);
        check("wr_busy_after", {31'd0, ba}, 32'd0);
        rw("rd10", 32'h10, 32'h0, 1'b0, 32'hDEADBEEF);

        rw("wr20", 32'h20, 32'h11112222, 1'b1, 32'h11112222);
        rw("rd20_adrchg", 32'h20, 32'h0, 1'b0, 32'h11112222);
        rw("rd10_intact", 32'h10, 32'h0, 1'b0, 32'hDEADBEEF);

        rw("wr100", 32'h100, 32'h12345678, 1'b1, 32'h12345678);
        rw("rd0_alias", 32'h0, 32'h0, 1'b0, 32'h12345678);
        rw("rd3_lowbits", 32'h3, 32'h0, 1'b0, 32'h12345678);
        rw("rd103_alias", 32'h103, 32'h0, 1'b0, 32'h12345678);

        // Reset during WAIT abandons the write.
        rw("wr30", 32'h30, 32'h0BADF00D, 1'b1, 32'h0BADF00D);
        adr = 32'h30; writedata = 32'hFFFFFFFF; memwrite = 1'b1; req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0; memwrite = 1'b0; reset = 1'b1;
        @(negedge clk);
        check("abort_busy_wait", {31'd0, busy}, 32'd1);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check("abort_ready", {31'd0, ready}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_readdata", readdata, 32'd0);
        @(negedge clk);
        check("abort_ready2", {31'd0, ready}, 32'd0);
        rw("rd30_prior", 32'h30, 32'h0, 1'b0, 32'h0BADF00D);

`ifdef MIPS_MEM_MMIO_EN
        rw("io_wr", 32'hFFFFFF00, 32'hA5, 1'b1, 32'hA5);
        check("io_out_a5", io_out, 32'h000000A5);
        rw("io_rd", 32'hFFFFFF00, 32'h0, 1'b0, 32'hA5);
        rw("io_rd_hole", 32'hFFFFFF08, 32'h0, 1'b0, 32'h0);
        xact(32'hFFFFFF04, 32'h0, 1'b0, rd0, lat, t0, b1, ra, ba);
        repeat (7) @(negedge clk);
        xact(32'hFFFFFF04, 32'h0, 1'b0, rd1, lat, t1, b1, ra, ba);
        check("cyc_delta", rd1 - rd0, 32'(t1 - t0));
        rw("cyc_wr", 32'hFFFFFF04, 32'h0, 1'b1, 32'h0);
        xact(32'hFFFFFF04, 32'h0, 1'b0, rd0, lat, t0, b1, ra, ba);
        check("cyc_after_wr", rd0 - rd1, 32'(t0 - t1));
`endif

        // LATENCY=1 with req held: alternating ready, one pulse per accept.
        @(negedge clk);
        adr_b = 32'h8; wd_b = 32'h00005A5A; we_b = 1'b1; req_b = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("l1_pulse", {31'd0, ready_b}, (i % 2 == 0) ? 32'd1 : 32'd0);
            if (ready_b) check("l1_echo", rd_b, 32'h00005A5A);
        end
        req_b = 1'b0; we_b = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("l1_idle_busy", {31'd0, busy_b}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
